// File: rtl/ct_f_spsram_init_wrap.sv
// Parametrised single-port SRAM wrapper with a hardware clear engine and held read data.
// Optional CT_SPSRAM_OUT_REG_EN adds an output register, which makes read latency 2 cycles.
module ct_f_spsram_init_wrap #(
    parameter int                          ADDR_WIDTH = 8,
    parameter int                          DATA_WIDTH = 7,
    parameter int                          WRAP_SIZE  = 1,
    parameter logic [DATA_WIDTH-1:0]       INIT_VALUE = '0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [ADDR_WIDTH-1:0]             A,
    input  logic                              CEN,
    input  logic                              GWEN,
    input  logic [DATA_WIDTH/WRAP_SIZE-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0]             D,
    output logic [DATA_WIDTH-1:0]             Q,
    input  logic                              INIT_REQ,
    output logic                              INIT_BUSY
);

    localparam int LANES = DATA_WIDTH / WRAP_SIZE;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    if (DATA_WIDTH % WRAP_SIZE != 0) begin : g_bad_geometry
        $error("ct_f_spsram_init_wrap: DATA_WIDTH must be a multiple of WRAP_SIZE");
    end

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_hold_reg;
    logic                    busy;
    logic                    func_en;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [LANES-1:0]        lane_we;
    logic [DATA_WIDTH-1:0]   lane_din;
    logic [DATA_WIDTH-1:0]   ram_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + ADDR_WIDTH'(1);
                if (cnt_reg == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (INIT_REQ) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy      = (state_reg == ST_INIT);
    assign INIT_BUSY = busy;
    assign func_en   = !busy && !CEN;

    // Deselected cycles re-read the last enabled address so the array output stays put.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_hold_reg <= '0;
        end else if (func_en) begin
            addr_hold_reg <= A;
        end
    end

    assign ram_addr = busy ? cnt_reg : (CEN ? addr_hold_reg : A);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WRAP_SIZE-1:0] mem [0:DEPTH-1];
        logic [WRAP_SIZE-1:0] rd_reg;

        assign lane_we[gi] = busy || (func_en && !GWEN && !WEN[gi]);
        assign lane_din[gi*WRAP_SIZE +: WRAP_SIZE] =
            busy ? INIT_VALUE[gi*WRAP_SIZE +: WRAP_SIZE] : D[gi*WRAP_SIZE +: WRAP_SIZE];

        // Read-first lane RAM: the registered read captures the pre-write contents.
        always_ff @(posedge CLK) begin
            if (lane_we[gi]) begin
                mem[ram_addr] <= lane_din[gi*WRAP_SIZE +: WRAP_SIZE];
            end
            rd_reg <= mem[ram_addr];
        end

        assign ram_q[gi*WRAP_SIZE +: WRAP_SIZE] = rd_reg;
    end

`ifdef CT_SPSRAM_OUT_REG_EN
    logic                  rd_en_reg;
    logic [DATA_WIDTH-1:0] out_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_en_reg <= 1'b0;
            out_reg   <= '0;
        end else begin
            rd_en_reg <= func_en;
            if (busy) begin
                out_reg <= '0;
            end else if (rd_en_reg) begin
                out_reg <= ram_q;
            end
        end
    end

    assign Q = busy ? '0 : out_reg;
`else
    assign Q = busy ? '0 : ram_q;
`endif

endmodule

// File: tb/tb_ct_f_spsram_init_wrap.sv
// Bench for ct_f_spsram_init_wrap: vector table plus scoreboard, and sweep/reset sequences.
module tb_ct_f_spsram_init_wrap;

`ifdef CT_SPSRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int SWEEP = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic       cen = 1'b1;
    logic       gwen = 1'b1;
    logic [6:0] wen = '1;
    logic [6:0] d = '0;
    logic [6:0] q;
    logic       init_req = 1'b0;
    logic       init_busy;

    always #5 clk = ~clk;

    ct_f_spsram_init_wrap #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(7),
        .WRAP_SIZE (1),
        .INIT_VALUE(7'h55)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .A        (a),
        .CEN      (cen),
        .GWEN     (gwen),
        .WEN      (wen),
        .D        (d),
        .Q        (q),
        .INIT_REQ (init_req),
        .INIT_BUSY(init_busy)
    );

    typedef struct {
        logic       cen;
        logic       gwen;
        logic [6:0] wen;
        logic [7:0] a;
        logic [6:0] d;
        logic       chk;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        int         t;
        logic       chk;
        logic [7:0] a;
        logic [6:0] exp;
    } sb_t;

    vec_t vecs[11];
    sb_t  sbq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle and retire every scoreboard entry whose latency has elapsed.
    task automatic step();
        sb_t e;
        @(negedge clk);
        cyc++;
        while (sbq.size() > 0 && (cyc - sbq[0].t) >= LAT) begin
            e = sbq.pop_front();
            if (e.chk) begin
                $display("[TB] cyc %0d read a=0x%02h q=0x%02h exp=0x%02h", cyc, e.a, q, e.exp);
                check("read_q", 32'(q), 32'(e.exp));
            end
        end
    endtask

    task automatic drive(input vec_t v);
        sb_t e;
        cen      = v.cen;
        gwen     = v.gwen;
        wen      = v.wen;
        a        = v.a;
        d        = v.d;
        init_req = 1'b0;
        e.t   = cyc;
        e.chk = v.chk;
        e.a   = v.a;
        e.exp = v.exp;
        sbq.push_back(e);
        step();
    endtask

    function automatic vec_t mk(input logic c, input logic g, input logic [6:0] w,
                                input logic [7:0] ad, input logic [6:0] dd, input logic [6:0] ex);
        vec_t v;
        v.cen = c; v.gwen = g; v.wen = w; v.a = ad; v.d = dd; v.chk = 1'b1; v.exp = ex;
        return v;
    endfunction

    task automatic rd(input logic [7:0] ad, input logic [6:0] ex);
        drive(mk(1'b0, 1'b1, 7'h7F, ad, 7'h00, ex));
    endtask

    task automatic go_idle();
        cen = 1'b1; gwen = 1'b1; wen = '1; init_req = 1'b0;
    endtask

    task automatic flush();
        go_idle();
        while (sbq.size() > 0) step();
    endtask

    // Counts sampled busy cycles starting at the current negedge; req_at pulses INIT_REQ,
    // stop_at returns early mid-sweep.
    task automatic count_busy(input int req_at, input int stop_at, output int n);
        go_idle();
        n = 0;
        while (init_busy && n < 2000) begin
            if (stop_at >= 0 && n == stop_at) return;
            init_req = (n == req_at);
            n++;
            step();
        end
        init_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = mk(1'b0, 1'b1, 7'h7F, 8'h00, 7'h00, 7'h55);
        vecs[1]  = mk(1'b0, 1'b1, 7'h7F, 8'h7F, 7'h00, 7'h55);
        vecs[2]  = mk(1'b0, 1'b1, 7'h7F, 8'hFF, 7'h00, 7'h55);
        vecs[3]  = mk(1'b0, 1'b0, 7'h00, 8'h10, 7'h7F, 7'h55);
        vecs[4]  = mk(1'b0, 1'b0, 7'h70, 8'h10, 7'h00, 7'h7F);
        vecs[5]  = mk(1'b0, 1'b1, 7'h7F, 8'h10, 7'h00, 7'h70);
        vecs[6]  = mk(1'b0, 1'b0, 7'h00, 8'h20, 7'h12, 7'h55);
        vecs[7]  = mk(1'b0, 1'b1, 7'h00, 8'h20, 7'h6B, 7'h12);
        vecs[8]  = mk(1'b0, 1'b0, 7'h00, 8'h30, 7'h3C, 7'h55);
        vecs[9]  = mk(1'b0, 1'b1, 7'h7F, 8'h30, 7'h00, 7'h3C);
        vecs[10] = mk(1'b0, 1'b1, 7'h7F, 8'h20, 7'h00, 7'h12);

        // Reset state and first sweep length
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(init_busy), 32'd1);
        check("reset_q", 32'(q), 32'd0);
        rst = 1'b0;
        count_busy(-1, -1, n);
        $display("[TB] initial sweep busy cycles=%0d", n);
        check("init_sweep_len", 32'(n), 32'(SWEEP));

        for (int i = 0; i < 11; i++) drive(vecs[i]);

        // Deselected hold with wandering address and write strobes that must be ignored
        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v = mk(1'b1, 1'b0, 7'h00, 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 7'h12);
            drive(v);
        end
        rd(8'h20, 7'h12);
        flush();

        // Asynchronous reset from IDLE clears Q at once and restarts the sweep
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(init_busy), 32'd1);
        check("async_rst_q", 32'(q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_busy(-1, -1, n);
        $display("[TB] sweep after idle reset busy cycles=%0d", n);
        check("rst_sweep_len", 32'(n), 32'(SWEEP));
        rd(8'h20, 7'h55);
        flush();

        // INIT_REQ coinciding with a write; a second request mid-sweep is ignored
        cen = 1'b0; gwen = 1'b0; wen = 7'h00; a = 8'h40; d = 7'h01; init_req = 1'b1;
        step();
        go_idle();
        check("req_busy_rise", 32'(init_busy), 32'd1);
        count_busy(50, -1, n);
        $display("[TB] requested sweep busy cycles=%0d", n);
        check("req_sweep_len", 32'(n), 32'(SWEEP));
        rd(8'h40, 7'h55);
        rd(8'h10, 7'h55);
        flush();

        // Reset at sweep count 100 aborts the sweep; a full sweep follows release
        init_req = 1'b1;
        step();
        go_idle();
        count_busy(-1, 100, n);
        check("mid_sweep_reached", 32'(n), 32'd100);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(init_busy), 32'd1);
        check("mid_rst_q", 32'(q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_busy(-1, -1, n);
        $display("[TB] sweep after mid-sweep reset busy cycles=%0d", n);
        check("mid_rst_sweep_len", 32'(n), 32'(SWEEP));

        // Partial-lane write once more after the restarted sweep
        drive(vecs[3]);
        drive(vecs[4]);
        drive(vecs[5]);
        rd(8'hFF, 7'h55);
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
